// File: rtl/digital_lock_pkg.sv
// ---------------------------------------------------------------------------
// digital_lock_pkg
// Shared definitions for the keypad code lock: the width of one keypad digit
// and the encoding of the lock's three top-level states.
// No ports (package).
// ---------------------------------------------------------------------------
package digital_lock_pkg;

  // One keypad digit is a 4-bit value (0..15 from the decoder).
  localparam int DIGIT_W = 4;

  // ENTRY   : collecting digits, idx counts digits matched so far
  // OPEN    : correct code entered, lock held open until relock
  // LOCKOUT : too many failures, all input ignored until the timer expires
  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_e;

endpackage

// File: rtl/digital_lock_timer.sv
// ---------------------------------------------------------------------------
// lock_timer
// Loadable down-counter that times the lockout period. A load pulse starts a
// countdown lasting CYCLES clock cycles, including the cycle right after the
// load edge. done is high during the final cycle of that countdown, so a
// controller that leaves its waiting state on done spends exactly CYCLES
// cycles waiting.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   load   in  1  start (or restart) the countdown
//   busy   out 1  countdown in progress
//   done   out 1  last cycle of the countdown
// ---------------------------------------------------------------------------
module lock_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count;
  logic             running;

  // Count register. Loading with CYCLES-1 rather than CYCLES makes the cycle
  // in which the count reads zero the last of CYCLES busy cycles. The count
  // saturates at zero; running drops on the edge that ends the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= CNT_W'(CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign busy = running;
  assign done = running && (count == '0);

endmodule

// File: rtl/digital_lock.sv
// ---------------------------------------------------------------------------
// digital_lock
// Keypad code lock. Digits arrive one per valid strobe and are compared in
// order against the four-digit code P0..P3. A complete correct sequence opens
// the lock until relock is pulsed. Each wrong digit ends the attempt with a
// one-cycle wrong_try_pulse; MAX_ATTEMPTS consecutive failures start a lockout
// of LOCKOUT_CYCLES cycles during which all input is ignored.
// Ports:
//   clk              in  1  rising-edge clock
//   rst_n            in  1  asynchronous active-low reset
//   digit            in  4  keypad digit, sampled when valid is high
//   valid            in  1  one-cycle strobe marking a new keypress
//   relock           in  1  one-cycle request to close the lock again
//   unlocked         out 1  lock is open (registered level)
//   wrong_try_pulse  out 1  one-cycle pulse per failed attempt (registered)
//   lockout          out 1  lockout timer running (registered level)
// ---------------------------------------------------------------------------
module digital_lock
  import digital_lock_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] P0             = 4'd1,
  parameter logic [DIGIT_W-1:0] P1             = 4'd2,
  parameter logic [DIGIT_W-1:0] P2             = 4'd3,
  parameter logic [DIGIT_W-1:0] P3             = 4'd4,
  parameter int                 MAX_ATTEMPTS   = 3,
  parameter int                 LOCKOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               valid,
  input  logic               relock,
  output logic               unlocked,
  output logic               wrong_try_pulse,
  output logic               lockout
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

  lock_state_e        state;
  lock_state_e        state_next;
  logic [1:0]         idx;
  logic [1:0]         idx_next;
  logic [ATT_W-1:0]   attempts;
  logic [ATT_W-1:0]   attempts_next;
  logic [DIGIT_W-1:0] expected_digit;
  logic               fail_now;
  logic               timer_load;
  logic               timer_busy;
  logic               timer_done;

  lock_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .busy  (timer_busy),
    .done  (timer_done)
  );

  // Code digit that the next keypress must match, chosen by how many digits
  // of the code have been matched so far.
  always_comb begin
    expected_digit = P0;
    case (idx)
      2'd0: expected_digit = P0;
      2'd1: expected_digit = P1;
      2'd2: expected_digit = P2;
      2'd3: expected_digit = P3;
      default: expected_digit = P0;
    endcase
  end

  // Next-state logic for the FSM, the digit index and the attempt counter.
  // In ENTRY, relock takes priority over a simultaneous keypress, so that
  // digit is dropped. A wrong digit is consumed by the failure and never
  // re-examined as the start of a new code. The attempt that triggers
  // lockout also reloads the timer.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    attempts_next = attempts;
    fail_now      = 1'b0;
    timer_load    = 1'b0;

    case (state)
      ENTRY: begin
        if (relock) begin
          idx_next = 2'd0;
        end else if (valid) begin
          if (digit == expected_digit) begin
            if (idx == 2'd3) begin
              state_next    = OPEN;
              idx_next      = 2'd0;
              attempts_next = '0;
            end else begin
              idx_next = idx + 2'd1;
            end
          end else begin
            fail_now = 1'b1;
            idx_next = 2'd0;
            if (int'(attempts) + 1 < MAX_ATTEMPTS) begin
              attempts_next = attempts + 1'b1;
            end else begin
              state_next    = LOCKOUT;
              attempts_next = '0;
              timer_load    = 1'b1;
            end
          end
        end
      end

      OPEN: begin
        if (relock) begin
          state_next    = ENTRY;
          idx_next      = 2'd0;
          attempts_next = '0;
        end
      end

      LOCKOUT: begin
        // The timer should always be busy while locked out; leaving when it
        // is not keeps the FSM from getting stuck if the two ever disagree.
        if (timer_done || !timer_busy) begin
          state_next = ENTRY;
          idx_next   = 2'd0;
        end
      end

      default: begin
        state_next    = ENTRY;
        idx_next      = 2'd0;
        attempts_next = '0;
      end
    endcase
  end

  // State, counters and outputs. The outputs are registered from the next
  // state so that unlocked and lockout change on the same edge as the state
  // itself, and lockout rises together with the pulse of the final failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ENTRY;
      idx             <= 2'd0;
      attempts        <= '0;
      unlocked        <= 1'b0;
      wrong_try_pulse <= 1'b0;
      lockout         <= 1'b0;
    end else begin
      state           <= state_next;
      idx             <= idx_next;
      attempts        <= attempts_next;
      unlocked        <= (state_next == OPEN);
      wrong_try_pulse <= fail_now;
      lockout         <= (state_next == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_digital_lock.sv
// ---------------------------------------------------------------------------
// tb_digital_lock
// Directed bench for digital_lock with code 1,2,3,4, MAX_ATTEMPTS=3 and
// LOCKOUT_CYCLES=80. Inputs change 1 ns after a rising edge and are held for
// exactly one edge; outputs are sampled 1 ns after that edge. Each check
// compares the packed {unlocked, wrong_try_pulse, lockout} triple.
// ---------------------------------------------------------------------------
module tb_digital_lock;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic       valid;
  logic       relock;
  logic       unlocked;
  logic       wrong_try_pulse;
  logic       lockout;

  int vectors;
  int miscompares;

  digital_lock #(
    .P0             (4'd1),
    .P1             (4'd2),
    .P2             (4'd3),
    .P3             (4'd4),
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (80)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .digit           (digit),
    .valid           (valid),
    .relock          (relock),
    .unlocked        (unlocked),
    .wrong_try_pulse (wrong_try_pulse),
    .lockout         (lockout)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one set of inputs across exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] d, input logic v, input logic r);
    digit  = d;
    valid  = v;
    relock = r;
    tick();
    digit  = 4'd0;
    valid  = 1'b0;
    relock = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    applyStimulus(d, 1'b1, 1'b0);
  endtask

  // Compare {unlocked, wrong_try_pulse, lockout} against the expected triple.
  task automatic checkOutput(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {unlocked, wrong_try_pulse, lockout};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed u/p/l=%b expected u/p/l=%b", tag, obs, exp);
    end
  endtask

  // Pull reset asynchronously between edges, check it takes effect at once,
  // then release it on a falling edge and realign to the sampling point.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(tag, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    digit       = 4'd0;
    valid       = 1'b0;
    relock      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("after_release", 3'b000);

    // 1. Correct code opens one cycle after the fourth strobe; input ignored when open
    press(4'd1); checkOutput("t1_d1", 3'b000);
    press(4'd2); checkOutput("t1_d2", 3'b000);
    press(4'd3); checkOutput("t1_d3", 3'b000);
    press(4'd4); checkOutput("t1_open", 3'b100);
    press(4'd9); checkOutput("t1_open_ignores_digit", 3'b100);

    // 2. Relock, then a wrong first digit gives one pulse
    applyStimulus(4'd0, 1'b0, 1'b1); checkOutput("t2_relock", 3'b000);
    press(4'd9); checkOutput("t2_fail1", 3'b010);
    tick();      checkOutput("t2_pulse_one_cycle", 3'b000);

    // 3. Two more failures; lockout rises with the third pulse
    press(4'd1); checkOutput("t3_d1", 3'b000);
    press(4'd9); checkOutput("t3_fail2", 3'b010);
    press(4'd0); checkOutput("t3_fail3_lockout", 3'b011);

    // 4. Lockout holds for 80 cycles in total regardless of input
    for (int i = 1; i < 80; i++) begin
      if (i <= 4)       press(4'(i));
      else if (i == 5)  press(4'd9);
      else if (i == 6)  applyStimulus(4'd0, 1'b0, 1'b1);
      else if (i == 79) press(4'd9);
      else              tick();
      checkOutput($sformatf("t4_lockout_hold_%0d", i), 3'b001);
    end
    // Digit on the edge that ends lockout is still ignored
    press(4'd9); checkOutput("t4_lockout_end", 3'b000);
    // First cycle after lockout accepts input normally
    press(4'd1); checkOutput("t4_d1", 3'b000);
    press(4'd2); checkOutput("t4_d2", 3'b000);
    press(4'd3); checkOutput("t4_d3", 3'b000);
    press(4'd4); checkOutput("t4_open", 3'b100);

    // 5. Success clears the attempt count
    applyStimulus(4'd0, 1'b0, 1'b1); checkOutput("t5_relock", 3'b000);
    press(4'd9); checkOutput("t5_fail1", 3'b010);
    press(4'd9); checkOutput("t5_fail2", 3'b010);
    press(4'd1); press(4'd2); press(4'd3);
    checkOutput("t5_partial", 3'b000);
    press(4'd4); checkOutput("t5_open", 3'b100);
    applyStimulus(4'd0, 1'b0, 1'b1); checkOutput("t5_relock2", 3'b000);
    press(4'd9); checkOutput("t5_fail_after_success", 3'b010);
    press(4'd9); checkOutput("t5_fail_second", 3'b010);
    press(4'd9); checkOutput("t5_fail_third_lockout", 3'b011);
    repeat (5) tick();
    checkOutput("t5_lockout_running", 3'b001);

    // 6. Reset mid-lockout and mid-entry
    async_reset("t6_reset_mid_lockout");
    checkOutput("t6_after_lockout_reset", 3'b000);
    press(4'd1); press(4'd2);
    checkOutput("t6_partial", 3'b000);
    async_reset("t6_reset_mid_entry");
    press(4'd3); checkOutput("t6_d3_fails", 3'b010);
    press(4'd4); checkOutput("t6_d4_fails", 3'b010);
    press(4'd9); checkOutput("t6_third_fail_lockout", 3'b011);
    async_reset("t6_reset_again");

    // Simultaneous valid and relock: relock wins, digit discarded, idx cleared
    press(4'd1); checkOutput("t7_d1", 3'b000);
    applyStimulus(4'd9, 1'b1, 1'b1); checkOutput("t7_valid_relock", 3'b000);
    tick();      checkOutput("t7_no_late_pulse", 3'b000);
    press(4'd1); press(4'd2); press(4'd3);
    checkOutput("t7_partial", 3'b000);
    press(4'd4); checkOutput("t7_open", 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
